// File: rtl/fifo_uart_tx.sv
// FIFO read-side UART transmitter: pops one word per frame and shifts it out LSB first.
// Optional even parity bit after the data bits when FIFO_UART_TX_PARITY_EN is defined.
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_WIDTH + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

`ifdef FIFO_UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_START, S_DATA, S_PARITY, S_STOP
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_START, S_DATA, S_STOP
  } state_e;
`endif

  state_e                state_q, state_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  rd_en_q, rd_en_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  timed;
  logic                  bit_end;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                  parity_q, parity_d;
`endif

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    rd_en_d = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    // Baud counter only runs while a bit is on the line; it wraps at each bit boundary.
    timed   = (state_q != S_IDLE) && (state_q != S_REQ) && (state_q != S_WAIT);
    bit_end = (baud_q == BAUD_LAST);
    if (timed) begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          state_d = S_REQ;
          rd_en_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      S_REQ: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        state_d = S_START;
        shift_d = fifo_dout;
        tx_d    = 1'b0;
        baud_d  = '0;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_d = ^fifo_dout;
`endif
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
`ifdef FIFO_UART_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = parity_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d   = bit_q + 1'b1;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          bit_d   = '0;
          tx_d    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            state_d = S_IDLE;
            bit_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      rd_en_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of every other flop.
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      rd_en_q  <= rd_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign fifo_rd_en = rd_en_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two instances (4 clk/bit 1 stop, 2 clk/bit 2 stops), each fed by a
// FIFO model, checked every cycle against a frame-level expected stream plus literal checks.
module tb_fifo_uart_tx;

  typedef struct packed {
    logic rd;
    logic busy;
    logic done;
    logic tx;
  } exp_t;

  localparam exp_t IDLE_EXP = 4'b0001;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int CPB_A = 4;
  localparam int SB_A  = 1;
  localparam int CPB_B = 2;
  localparam int SB_B  = 2;
  localparam int FRAME_CYC_A = (PAR_EN ? 11 : 10) * CPB_A;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // FIFO models: storage written by the stimulus, read pointer advanced on each pop.
  logic [7:0] mem_a [64];
  logic [7:0] mem_b [64];
  int pushed_a = 0, popped_a = 0, pushed_b = 0, popped_b = 0;
  logic [7:0] dout_a = '0, dout_b = '0;
  logic empty_a, empty_b;
  assign empty_a = (pushed_a == popped_a);
  assign empty_b = (pushed_b == popped_b);

  logic rd_a, tx_a, busy_a, done_a;
  logic rd_b, tx_b, busy_b, done_b;

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB_A), .STOP_BITS(SB_A)) u_a (
    .clk(clk), .rst_n(rst_n), .fifo_empty(empty_a), .fifo_dout(dout_a),
    .fifo_rd_en(rd_a), .tx(tx_a), .busy(busy_a), .frame_done(done_a)
  );

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB_B), .STOP_BITS(SB_B)) u_b (
    .clk(clk), .rst_n(rst_n), .fifo_empty(empty_b), .fifo_dout(dout_b),
    .fifo_rd_en(rd_b), .tx(tx_b), .busy(busy_b), .frame_done(done_b)
  );

  exp_t eq_a[$];
  exp_t eq_b[$];
  exp_t frame_q[$];
  exp_t cur_a = IDLE_EXP;
  exp_t cur_b = IDLE_EXP;

  int total = 0, bad = 0;
  int rd_cnt_a = 0, rd_cnt_b = 0, done_cnt_a = 0, done_cnt_b = 0;

  // Whole-frame expected output stream, one entry per clk cycle after the pop decision.
  task automatic build(input logic [7:0] w, input int cpb, input int sb);
    logic line[$];
    frame_q.delete();
    frame_q.push_back(4'b1101);
    frame_q.push_back(4'b0101);
    line.push_back(1'b0);
    for (int i = 0; i < 8; i++) line.push_back(w[i]);
    if (PAR_EN) line.push_back(^w);
    for (int i = 0; i < sb; i++) line.push_back(1'b1);
    foreach (line[k]) begin
      for (int c = 0; c < cpb; c++) frame_q.push_back({3'b010, line[k]});
    end
    frame_q.push_back(4'b0011);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eq_a.delete();
      eq_b.delete();
      cur_a <= IDLE_EXP;
      cur_b <= IDLE_EXP;
    end else begin
      if (eq_a.size() == 0 && pushed_a != popped_a) begin
        build(mem_a[popped_a], CPB_A, SB_A);
        foreach (frame_q[k]) eq_a.push_back(frame_q[k]);
      end
      if (eq_b.size() == 0 && pushed_b != popped_b) begin
        build(mem_b[popped_b], CPB_B, SB_B);
        foreach (frame_q[k]) eq_b.push_back(frame_q[k]);
      end
      cur_a <= (eq_a.size() != 0) ? eq_a.pop_front() : IDLE_EXP;
      cur_b <= (eq_b.size() != 0) ? eq_b.pop_front() : IDLE_EXP;
      if (rd_a && pushed_a != popped_a) begin
        dout_a   <= mem_a[popped_a];
        popped_a <= popped_a + 1;
      end
      if (rd_b && pushed_b != popped_b) begin
        dout_b   <= mem_b[popped_b];
        popped_b <= popped_b + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one cycle and compare both instances against the model.
  task automatic step();
    @(negedge clk);
    if (rst_n) begin
      check("a_tx", tx_a, cur_a.tx);
      check("a_busy", busy_a, cur_a.busy);
      check("a_done", done_a, cur_a.done);
      check("a_rd", rd_a, cur_a.rd);
      check("b_tx", tx_b, cur_b.tx);
      check("b_busy", busy_b, cur_b.busy);
      check("b_done", done_b, cur_b.done);
      check("b_rd", rd_b, cur_b.rd);
      if (rd_a) rd_cnt_a++;
      if (rd_b) rd_cnt_b++;
      if (done_a) done_cnt_a++;
      if (done_b) done_cnt_b++;
    end
  endtask

  task automatic push_a(input logic [7:0] w);
    mem_a[pushed_a] = w;
    pushed_a++;
  endtask

  task automatic push_b(input logic [7:0] w);
    mem_b[pushed_b] = w;
    pushed_b++;
  endtask

  // Waits for the start bit of u_a, samples each bit mid-way, returns at the frame_done cycle.
  task automatic grab_a(output logic [11:0] bits, output int cyc, output int gap);
    bits = '0;
    cyc  = 0;
    gap  = 0;
    while (tx_a !== 1'b0 && gap < 200) begin
      step();
      gap++;
    end
    check("a_start_timeout", gap < 200, 1);
    while (done_a !== 1'b1 && cyc < 200) begin
      if (cyc % CPB_A == 1 && cyc / CPB_A < 12) bits[cyc / CPB_A] = tx_a;
      step();
      cyc++;
    end
    check("a_done_timeout", cyc < 200, 1);
  endtask

  logic [11:0] bits;
  int cyc, gap, run, n, stop_idx;

  initial begin
    stop_idx = PAR_EN ? 10 : 9;
    #1 rst_n = 1'b0;
    #2;
    check("rst_tx", tx_a, 1);
    check("rst_busy", busy_a, 0);
    check("rst_rd", rd_a, 0);
    check("rst_done", done_a, 0);
    check("rst_tx_b", tx_b, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Empty FIFO: nothing happens.
    repeat (100) step();
    check("empty_no_pop", rd_cnt_a, 0);
    check("empty_tx", tx_a, 1);
    check("empty_busy", busy_a, 0);

    // Single word 0xA5.
    push_a(8'hA5);
    grab_a(bits, cyc, gap);
    check("a5_bits", bits[8:0], 9'b1_0100_1010);
    check("a5_stop", bits[stop_idx], 1);
    check("a5_len", cyc, FRAME_CYC_A);
    check("a5_model_done", cur_a, 4'b0011);
    step();
    step();
    check("a5_one_pop", rd_cnt_a, 1);
    check("a5_one_done", done_cnt_a, 1);
    check("a5_busy_after", busy_a, 0);

    // Back-to-back 0x00 then 0xFF.
    rd_cnt_a = 0;
    push_a(8'h00);
    push_a(8'hFF);
    grab_a(bits, cyc, gap);
    check("b2b_first", bits[8:1], 8'h00);
    grab_a(bits, cyc, gap);
    check("b2b_gap", gap, 3);
    check("b2b_second", bits[8:1], 8'hFF);
    repeat (30) step();
    check("b2b_two_pops", rd_cnt_a, 2);

    // Reset during data bit 3 of 0x81 (bit 3 is 0, so the line is low at that moment).
    push_a(8'h81);
    n = 0;
    while (tx_a !== 1'b0 && n < 50) begin
      step();
      n++;
    end
    check("rst_start_timeout", n < 50, 1);
    repeat (17) step();
    check("pre_rst_tx", tx_a, 0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_tx", tx_a, 1);
    check("midrst_busy", busy_a, 0);
    check("midrst_rd", rd_a, 0);
    step();
    step();
    rst_n = 1'b1;
    push_a(8'h3C);
    grab_a(bits, cyc, gap);
    check("after_rst_word", bits[8:1], 8'h3C);
    check("after_rst_len", cyc, FRAME_CYC_A);

`ifdef FIFO_UART_TX_PARITY_EN
    push_a(8'h07);
    push_a(8'h03);
    grab_a(bits, cyc, gap);
    check("par_07", bits[9], 1);
    check("par_07_len", cyc, 44);
    grab_a(bits, cyc, gap);
    check("par_03", bits[9], 0);
    check("par_03_len", cyc, 44);
`endif

    // Two stop bits at 2 clk/bit on u_b; bit 7 of 0x5A is 0 so the high run is the stop phase.
    push_b(8'h5A);
    run = 0;
    n = 0;
    do begin
      step();
      n++;
      if (done_b !== 1'b1) run = (tx_b === 1'b1 && busy_b === 1'b1) ? run + 1 : 0;
    end while (done_b !== 1'b1 && n < 300);
    check("b_done_timeout", n < 300, 1);
    check("b_stop_len", run, 4);
    repeat (5) step();
    check("b_one_done", done_cnt_b, 1);
    check("b_one_pop", rd_cnt_b, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Read-side consumer for the synchronous FIFO.
- Pops one word at a time from the FIFO and serialises it onto a UART-style line: start bit, DATA_WIDTH data bits LSB first, optional parity bit, then stop bit(s).
- Sits directly downstream of the FIFO's read port and is the chip-level serial output stage.
- Paces FIFO reads itself; the FIFO is never over-read.

Parameters:
- DATA_WIDTH, 8, word width; must match FIFO DATA_WIDTH.
- CLKS_PER_BIT, 16, clk cycles per serial bit; legal range 2 or more.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- fifo_empty  input  1  FIFO empty flag.
- fifo_dout  input  DATA_WIDTH  FIFO read data; registered in FIFO, valid the cycle after the edge that sampled fifo_rd_en high.
- fifo_rd_en  output  1  FIFO pop request, registered, single-cycle pulse.
- tx  output  1  serial line, idle high.
- busy  output  1  high from pop request through last stop bit.
- frame_done  output  1  single-cycle pulse at end of last stop bit.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset (rst_n low, immediate, no clock needed):
  - tx=1, fifo_rd_en=0, busy=0, frame_done=0.
  - State IDLE; baud counter, bit counter and shift register cleared.
- Reset mid-frame: tx returns high immediately; the in-flight word is dropped. After release, normal operation resumes from IDLE.
- States: IDLE, REQ, WAIT, START, DATA, PARITY (only if PARITY_EN), STOP.
- IDLE:
  - Edge sampling fifo_empty=0 -> REQ; fifo_rd_en=1, busy=1.
  - fifo_empty=1 -> stay; fifo_rd_en=0.
- REQ (1 cycle): fifo_rd_en=1 during this cycle; next edge -> WAIT, fifo_rd_en=0.
- WAIT (1 cycle): next edge loads shift register <= fifo_dout, tx=0 -> START.
- START, DATA, PARITY, STOP each bit last exactly CLKS_PER_BIT cycles, timed by a baud counter of width $clog2(CLKS_PER_BIT) counting 0..CLKS_PER_BIT-1.
- Bit transitions occur on the edge where the counter equals CLKS_PER_BIT-1; the counter then resets to 0.
- DATA:
  - tx = shift register bit 0; shift right at each bit boundary.
  - Bit counter 0..DATA_WIDTH-1; after bit DATA_WIDTH-1 -> PARITY if enabled, else STOP.
- STOP:
  - tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - At its final edge: frame_done=1 for one cycle, busy=0, -> IDLE.
- Latency: tx falls 2 edges after the IDLE edge that saw fifo_empty=0. Gap between back-to-back frames is 3 clk cycles of idle-high line (IDLE, REQ, WAIT).
- fifo_empty is sampled only in IDLE. The minimum frame length of 20 cycles guarantees the FIFO flags have settled, so no extra guard is needed.
- fifo_rd_en is never asserted while fifo_empty=1 in IDLE, and at most once per frame.
- FIFO refilled mid-frame: ignored until IDLE.
- Frame bit count is DATA_WIDTH + 1 + STOP_BITS (+1 with parity).

Optional Feature:
- Macro: FIFO_UART_TX_PARITY_EN.
- Defined:
  - PARITY state inserted after DATA; tx = even parity (XOR reduction of the loaded word) for CLKS_PER_BIT cycles.
  - Parity is computed from the word captured at WAIT->START, not from the shifted register.
- Undefined: no PARITY state, no parity logic synthesised; DATA goes directly to STOP.

Test Plan:
- Single word, CLKS_PER_BIT=4, no parity: FIFO holds 0xA5 -> one fifo_rd_en pulse. tx sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; frame_done pulses once; busy low afterwards.
- Empty FIFO held 100 cycles after reset -> fifo_rd_en never asserts; tx=1; busy=0.
- Back-to-back: FIFO holds 0x00, 0xFF -> two pops, two frames in order, exactly 3 idle-high cycles between the first stop bit and the second start bit; no third pop.
- Reset mid-frame: assert rst_n=0 during data bit 3 -> tx=1 and busy=0 with no clock edge. After release with FIFO holding 0x3C, the next frame carries 0x3C cleanly.
- FIFO_UART_TX_PARITY_EN defined, words 0x07 then 0x03 -> parity bit 1 then 0; frame 11 bits long.
- STOP_BITS=2, CLKS_PER_BIT=2 -> stop phase lasts 4 cycles; frame_done is asserted at its final cycle.
